// File: rtl/llc_sched_pkg.sv
// Shared types and defaults for the LLC port scheduler and its write buffer.
package llc_sched_pkg;

  localparam int STARVE_MAX_DEFAULT = 3;
  localparam int OFFS_W_DEFAULT     = 5;
  localparam int LINE_W_DEFAULT     = 256;

  typedef logic [LINE_W_DEFAULT-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    WB_DRAIN,
    DONE_I,
    DONE_D
  } sched_state_t;

endpackage

// File: rtl/llc_port_scheduler_wb_entry.sv
// One-entry posted write buffer: holds a single D-cache writeback line and
// reports whether a probe tag hits the held line.
module wb_entry
  import llc_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int OFFS_W = OFFS_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     clear,
  input  logic [ADDR_W-OFFS_W-1:0] tag,
  input  logic [LINE_W-1:0]        data,
  input  logic [ADDR_W-OFFS_W-1:0] probe_tag,
  output logic                     valid,
  output logic [ADDR_W-1:0]        stored_addr,
  output logic [LINE_W-1:0]        stored_data,
  output logic                     match
);

  logic [ADDR_W-OFFS_W-1:0] tag_q;

  // Capture on load, invalidate on clear; reset discards any buffered line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid       <= 1'b0;
      tag_q       <= '0;
      stored_data <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid       <= 1'b1;
      tag_q       <= tag;
      stored_data <= data;
    end
  end

  assign stored_addr = {tag_q, {OFFS_W{1'b0}}};
  assign match       = valid && (probe_tag == tag_q);

endmodule

// File: rtl/llc_port_scheduler.sv
// Arbitrates the single LLC line port between the I-cache and D-cache, with
// D-read priority, bounded I starvation and a one-entry posted write buffer.
module llc_port_scheduler
  import llc_sched_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = LINE_W_DEFAULT,
  parameter int OFFS_W     = OFFS_W_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              llc_read,
  output logic              llc_write,
  output logic [ADDR_W-1:0] llc_addr,
  output logic [LINE_W-1:0] llc_wdata,
  input  logic [LINE_W-1:0] llc_rdata,
  input  logic              llc_resp
);

  localparam int TAG_W = ADDR_W - OFFS_W;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  sched_state_t      state, next_state;
  logic [CNT_W-1:0]  starve_cnt, starve_next;
  logic [TAG_W-1:0]  rd_tag, rd_tag_next;
  logic [TAG_W-1:0]  i_tag, d_tag;
  logic              wb_load, wb_clear, wb_valid, wb_match, fwd_hit;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_data;
  logic              addr_unused;

  assign i_tag       = i_addr[ADDR_W-1:OFFS_W];
  assign d_tag       = d_addr[ADDR_W-1:OFFS_W];
  assign addr_unused = ^{i_addr[OFFS_W-1:0], d_addr[OFFS_W-1:0]};

  wb_entry #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .OFFS_W (OFFS_W)
  ) u_wb (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (wb_load),
    .clear       (wb_clear),
    .tag         (d_tag),
    .data        (d_wdata),
    .probe_tag   (d_tag),
    .valid       (wb_valid),
    .stored_addr (wb_addr),
    .stored_data (wb_data),
    .match       (wb_match)
  );

  // Next-state and arbitration; only IDLE grants, DONE states never re-grant.
  always_comb begin
    next_state  = state;
    starve_next = starve_cnt;
    rd_tag_next = rd_tag;
    wb_load     = 1'b0;
    wb_clear    = 1'b0;
    fwd_hit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_read && wb_match) begin
          fwd_hit    = 1'b1;
          next_state = DONE_D;
        end else if (d_write && wb_valid) begin
          next_state = WB_DRAIN;
        end else if (d_write) begin
          wb_load    = 1'b1;
          next_state = DONE_D;
        end else if (d_read && i_read) begin
          if (starve_cnt == STARVE_LIMIT) begin
            next_state  = I_RD;
            starve_next = '0;
            rd_tag_next = i_tag;
          end else begin
            next_state  = D_RD;
            starve_next = starve_cnt + CNT_W'(1);
            rd_tag_next = d_tag;
          end
        end else if (d_read) begin
          next_state  = D_RD;
          rd_tag_next = d_tag;
        end else if (i_read) begin
          next_state  = I_RD;
          starve_next = '0;
          rd_tag_next = i_tag;
        end else if (wb_valid) begin
          next_state = WB_DRAIN;
        end
      end
      I_RD:     if (llc_resp) next_state = DONE_I;
      D_RD:     if (llc_resp) next_state = DONE_D;
      WB_DRAIN: begin
        if (llc_resp) begin
          wb_clear   = 1'b1;
          next_state = IDLE;
        end
      end
      DONE_I, DONE_D: next_state = IDLE;
      default:        next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Starvation counter, issued read tag and returned-line registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      rd_tag     <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      starve_cnt <= starve_next;
      rd_tag     <= rd_tag_next;
      if (state == I_RD && llc_resp) i_rdata <= llc_rdata;
      if (state == D_RD && llc_resp) d_rdata <= llc_rdata;
      else if (fwd_hit)              d_rdata <= wb_data;
    end
  end

  // LLC request outputs decoded from the registered state and address.
  always_comb begin
    llc_addr = '0;
    if (state == I_RD || state == D_RD) llc_addr = {rd_tag, {OFFS_W{1'b0}}};
    else if (state == WB_DRAIN)         llc_addr = wb_addr;
  end

  assign llc_read  = (state == I_RD) || (state == D_RD);
  assign llc_write = (state == WB_DRAIN);
  assign llc_wdata = llc_write ? wb_data : '0;
  assign i_resp    = (state == DONE_I);
  assign d_resp    = (state == DONE_D);

endmodule

// File: tb/tb_llc_port_scheduler.sv
// Directed self-checking bench for llc_port_scheduler; the bench plays the
// role of both L1 caches and the cacheline adapter.
module tb_llc_port_scheduler;
  import llc_sched_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read;
  logic [31:0]  i_addr;
  line_t        i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  line_t        d_wdata;
  line_t        d_rdata;
  logic         d_resp;
  logic         llc_read;
  logic         llc_write;
  logic [31:0]  llc_addr;
  line_t        llc_wdata;
  line_t        llc_rdata;
  logic         llc_resp;

  int checks = 0;
  int errors = 0;

  llc_port_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .llc_read  (llc_read),
    .llc_write (llc_write),
    .llc_addr  (llc_addr),
    .llc_wdata (llc_wdata),
    .llc_rdata (llc_rdata),
    .llc_resp  (llc_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [31:0] da, input line_t dwd);
    i_read  = ir;
    i_addr  = ia;
    d_read  = dr;
    d_write = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  // Waits for an LLC request, holds it for 'delay' cycles, then pulses llc_resp.
  // Returns at the first falling edge after the response was sampled.
  task automatic serveLlc(input string tag, input int delay, input line_t data,
                          output logic was_write, output logic [31:0] addr,
                          output line_t wdata, output logic [1:0] cnt);
    int n = 0;
    while (!(llc_read || llc_write) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_req_seen"}, 256'(llc_read || llc_write), 256'(1));
    checkOutput({tag, "_rw_excl"}, 256'(llc_read && llc_write), 256'(0));
    was_write = llc_write;
    addr      = llc_addr;
    wdata     = llc_wdata;
    cnt       = dut.starve_cnt;
    repeat (delay) @(negedge clk);
    checkOutput({tag, "_addr_stable"}, 256'(llc_addr), 256'(addr));
    llc_rdata = data;
    llc_resp  = 1'b1;
    @(negedge clk);
    llc_resp  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        w;
    logic [31:0] a;
    line_t       wd;
    logic [1:0]  cnt;
    line_t       d1, d2, d3, rd_line;
    int          n;

    d1 = {8{32'hD1D1_0001}};
    d2 = {8{32'hD2D2_0002}};
    d3 = {8{32'hD3D3_0003}};

    reset_n   = 1'b0;
    llc_resp  = 1'b0;
    llc_rdata = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ctrl", 256'({llc_read, llc_write, i_resp, d_resp}), 256'(0));
    checkOutput("rst_llc_addr", 256'(llc_addr), 256'(0));
    checkOutput("rst_llc_wdata", llc_wdata, 256'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // I-cache miss through the adapter.
    applyStimulus(1'b1, 32'h0000_1044, 1'b0, 1'b0, 32'h0, '0);
    serveLlc("iread", 8, {32{8'hA5}}, w, a, wd, cnt);
    checkOutput("iread_is_read", 256'(w), 256'(0));
    checkOutput("iread_addr", 256'(a), 256'(32'h0000_1040));
    checkOutput("iread_i_resp", 256'(i_resp), 256'(1));
    checkOutput("iread_i_rdata", i_rdata, {32{8'hA5}});
    checkOutput("iread_llc_drop", 256'(llc_read), 256'(0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    checkOutput("iread_pulse_end", 256'(i_resp), 256'(0));

    // Posted write, forward hit, then opportunistic drain.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2000, d1);
    @(negedge clk);
    checkOutput("posted_d_resp", 256'(d_resp), 256'(1));
    checkOutput("posted_no_llc", 256'({llc_read, llc_write}), 256'(0));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2010, '0);
    @(negedge clk);
    checkOutput("posted_pulse_end", 256'(d_resp), 256'(0));
    @(negedge clk);
    checkOutput("fwd_d_resp", 256'(d_resp), 256'(1));
    checkOutput("fwd_d_rdata", d_rdata, d1);
    checkOutput("fwd_no_llc_read", 256'(llc_read), 256'(0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    serveLlc("drain1", 3, '0, w, a, wd, cnt);
    checkOutput("drain1_is_write", 256'(w), 256'(1));
    checkOutput("drain1_addr", 256'(a), 256'(32'h0000_2000));
    checkOutput("drain1_wdata", wd, d1);
    checkOutput("drain1_clear", 256'(dut.wb_valid), 256'(0));

    // Write into a full buffer: old line drains first, new line then posted.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2000, d1);
    @(negedge clk);
    checkOutput("reload_d_resp", 256'(d_resp), 256'(1));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3000, d2);
    serveLlc("drain2", 2, '0, w, a, wd, cnt);
    checkOutput("drain2_is_write", 256'(w), 256'(1));
    checkOutput("drain2_addr", 256'(a), 256'(32'h0000_2000));
    checkOutput("drain2_wdata", wd, d1);
    checkOutput("drain2_no_resp_yet", 256'(d_resp), 256'(0));
    checkOutput("drain2_write_once_a", 256'(llc_write), 256'(0));
    @(negedge clk);
    checkOutput("drain2_d_resp", 256'(d_resp), 256'(1));
    checkOutput("drain2_write_once_b", 256'(llc_write), 256'(0));
    checkOutput("drain2_new_addr", 256'(dut.wb_addr), 256'(32'h0000_3000));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    serveLlc("drain3", 1, '0, w, a, wd, cnt);
    checkOutput("drain3_addr", 256'(a), 256'(32'h0000_3000));
    checkOutput("drain3_wdata", wd, d2);

    // Both requesters held: D,D,D,I,D,D,D,I with the counter reset on each I.
    applyStimulus(1'b1, 32'h0000_4008, 1'b1, 1'b0, 32'h0000_5010, '0);
    for (int k = 0; k < 8; k++) begin
      rd_line = {8{32'hC0DE_0000 + 32'(k)}};
      serveLlc("starve", 2, rd_line, w, a, wd, cnt);
      if (k % 4 == 3) begin
        checkOutput("starve_i_addr", 256'(a), 256'(32'h0000_4000));
        checkOutput("starve_i_cnt", 256'(cnt), 256'(0));
        checkOutput("starve_i_resp", 256'({i_resp, d_resp}), 256'(2'b10));
        checkOutput("starve_i_rdata", i_rdata, rd_line);
      end else begin
        checkOutput("starve_d_addr", 256'(a), 256'(32'h0000_5000));
        checkOutput("starve_d_cnt", 256'(cnt), 256'(k % 4 + 1));
        checkOutput("starve_d_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        checkOutput("starve_d_rdata", d_rdata, rd_line);
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);

    // Buffered write bypassed by a missing D read, then async reset mid-read.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_7000, d3);
    @(negedge clk);
    checkOutput("bypass_posted_resp", 256'(d_resp), 256'(1));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_6000, '0);
    n = 0;
    while (!llc_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bypass_llc_read", 256'(llc_read), 256'(1));
    checkOutput("bypass_llc_addr", 256'(llc_addr), 256'(32'h0000_6000));
    checkOutput("bypass_wb_held", 256'(dut.wb_valid), 256'(1));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", 256'({llc_read, llc_write, i_resp, d_resp}), 256'(0));
    checkOutput("async_rst_addr", 256'(llc_addr), 256'(0));
    checkOutput("async_rst_d_rdata", d_rdata, 256'(0));
    checkOutput("async_rst_i_rdata", i_rdata, 256'(0));
    checkOutput("async_rst_wb", 256'(dut.wb_valid), 256'(0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Stray adapter response while idle must be ignored.
    llc_rdata = {64{4'hF}};
    llc_resp  = 1'b1;
    @(negedge clk);
    llc_resp  = 1'b0;
    checkOutput("stray_no_resp", 256'({i_resp, d_resp}), 256'(0));
    checkOutput("stray_no_llc", 256'({llc_read, llc_write}), 256'(0));
    checkOutput("stray_rdata_hold", d_rdata, 256'(0));
    repeat (3) @(negedge clk);
    checkOutput("no_drain_after_rst", 256'({llc_read, llc_write, d_resp}), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
